// File: rtl/select_array_scheduler.sv
// select_array_scheduler: sequences one TnKK select-array tile pass,
// issuing buffer reads and tagging beats for the accumulator.
module select_array_scheduler #(
  parameter int Tm              = 4,
  parameter int CNT_WIDTH       = 8,
  parameter int FEAT_ADDR_WIDTH = 8,
  parameter int WGT_ADDR_WIDTH  = 12,
  parameter int SET_WIDTH       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       cfg_in_tiles,
  input  logic [CNT_WIDTH-1:0]       cfg_out_sets,
  input  logic [FEAT_ADDR_WIDTH-1:0] cfg_feat_base,
  input  logic [WGT_ADDR_WIDTH-1:0]  cfg_wgt_base,
  input  logic                       acc_ready,
  input  logic                       array_done,
  output logic                       feat_rd_en,
  output logic [FEAT_ADDR_WIDTH-1:0] feat_rd_addr,
  output logic                       wgt_rd_en,
  output logic [WGT_ADDR_WIDTH-1:0]  wgt_rd_addr,
  output logic                       array_enable,
  output logic                       acc_valid,
  output logic                       acc_first,
  output logic                       acc_last,
  output logic [SET_WIDTH-1:0]       acc_set,
  output logic                       busy,
  output logic                       done,
  output logic                       err_seq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                 v;
    logic                 first;
    logic                 last;
    logic [SET_WIDTH-1:0] set;
  } tag_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_WIDTH-1:0]       r_n;
  logic [CNT_WIDTH-1:0]       r_m_sets;
  logic [FEAT_ADDR_WIDTH-1:0] r_feat_base;
  logic [WGT_ADDR_WIDTH-1:0]  r_wgt_base;

  logic [CNT_WIDTH-1:0]       r_t;
  logic [CNT_WIDTH-1:0]       r_m;
  logic [WGT_ADDR_WIDTH-1:0]  r_woff;

  tag_t r_s1;
  tag_t r_s2;
  logic r_err;

  logic w_accept;
  logic w_bad_cfg;
  logic w_issue;
  logic w_t_last;
  logic w_m_last;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_bad_cfg = (cfg_in_tiles == '0)
                  || (cfg_out_sets == '0)
                  || (cfg_out_sets > CNT_WIDTH'(Tm));
  assign w_t_last  = (r_t == r_n - CNT_WIDTH'(1));
  assign w_m_last  = (r_m == r_m_sets - CNT_WIDTH'(1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state and control decode
  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    w_issue = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_bad_cfg ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        w_issue = acc_ready;
        if (acc_ready && w_t_last && w_m_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // stage 2 empties on this edge once stage 1 is empty
        if (!r_s1.v) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // latch pass configuration on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n         <= '0;
      r_m_sets    <= '0;
      r_feat_base <= '0;
      r_wgt_base  <= '0;
    end else if (w_accept) begin
      r_n         <= cfg_in_tiles;
      r_m_sets    <= cfg_out_sets;
      r_feat_base <= cfg_feat_base;
      r_wgt_base  <= cfg_wgt_base;
    end
  end

  // tile / set / weight-offset counters advance on each issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t    <= '0;
      r_m    <= '0;
      r_woff <= '0;
    end else if (w_accept) begin
      r_t    <= '0;
      r_m    <= '0;
      r_woff <= '0;
    end else if (w_issue) begin
      r_woff <= r_woff + WGT_ADDR_WIDTH'(1);
      if (w_t_last) begin
        r_t <= '0;
        r_m <= r_m + CNT_WIDTH'(1);
      end else begin
        r_t <= r_t + CNT_WIDTH'(1);
      end
    end
  end

  // two-stage tag pipeline: stage 1 = array enable, stage 2 = done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1.v     <= w_issue;
      r_s1.first <= w_issue && (r_t == '0);
      r_s1.last  <= w_issue && w_t_last;
      r_s1.set   <= w_issue ? r_m[SET_WIDTH-1:0] : '0;
      r_s2       <= r_s1;
    end
  end

  // sticky sequencing error: array done must track expected tags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (array_done != r_s2.v) begin
      r_err <= 1'b1;
    end
  end

  assign feat_rd_en   = w_issue;
  assign wgt_rd_en    = w_issue;
  assign feat_rd_addr = r_feat_base + FEAT_ADDR_WIDTH'(r_t);
  assign wgt_rd_addr  = r_wgt_base + r_woff;
  assign array_enable = r_s1.v;
  assign acc_valid    = r_s2.v;
  assign acc_first    = r_s2.first;
  assign acc_last     = r_s2.last;
  assign acc_set      = r_s2.set;
  assign err_seq      = r_err;

endmodule

// File: tb/tb_select_array_scheduler.sv
// tb_select_array_scheduler: directed and randomized passes checked
// against a per-beat model of the tile/set walk.
module tb_select_array_scheduler;
  localparam int TM = 4;
  localparam int CW = 8;
  localparam int FW = 8;
  localparam int WW = 12;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_in_tiles = '0;
  logic [CW-1:0] cfg_out_sets = '0;
  logic [FW-1:0] cfg_feat_base = '0;
  logic [WW-1:0] cfg_wgt_base = '0;
  logic          acc_ready = 1'b1;
  logic          array_done;
  logic          feat_rd_en;
  logic [FW-1:0] feat_rd_addr;
  logic          wgt_rd_en;
  logic [WW-1:0] wgt_rd_addr;
  logic          array_enable;
  logic          acc_valid;
  logic          acc_first;
  logic          acc_last;
  logic [SW-1:0] acc_set;
  logic          busy;
  logic          done;
  logic          err_seq;

  logic late = 1'b0;
  logic d1 = 1'b0;
  logic d2 = 1'b0;

  int total = 0;
  int bad = 0;

  select_array_scheduler #(
    .Tm(TM), .CNT_WIDTH(CW), .FEAT_ADDR_WIDTH(FW),
    .WGT_ADDR_WIDTH(WW), .SET_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_tiles(cfg_in_tiles), .cfg_out_sets(cfg_out_sets),
    .cfg_feat_base(cfg_feat_base), .cfg_wgt_base(cfg_wgt_base),
    .acc_ready(acc_ready), .array_done(array_done),
    .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
    .array_enable(array_enable), .acc_valid(acc_valid),
    .acc_first(acc_first), .acc_last(acc_last), .acc_set(acc_set),
    .busy(busy), .done(done), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  // select array model: registered done one cycle after enable
  always @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= array_enable;
      d2 <= d1;
    end
  end
  assign array_done = late ? d2 : d1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_feat_en"}, feat_rd_en, 0);
    chk({tag, "_feat_addr"}, feat_rd_addr, 0);
    chk({tag, "_wgt_en"}, wgt_rd_en, 0);
    chk({tag, "_wgt_addr"}, wgt_rd_addr, 0);
    chk({tag, "_arr_en"}, array_enable, 0);
    chk({tag, "_acc_v"}, acc_valid, 0);
    chk({tag, "_acc_f"}, acc_first, 0);
    chk({tag, "_acc_l"}, acc_last, 0);
    chk({tag, "_acc_set"}, acc_set, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_seq, 0);
  endtask

  // mode 0: ready always; 1: 3-cycle stall after first issue;
  // 2: random ready plus start/config noise while busy
  task automatic run_pass(input int n, input int m, input int fb,
                          input int wb, input int mode,
                          input bit exp_err);
    int  iss[0:511];
    int  beat[0:511];
    int  nexp;
    int  issued;
    int  last_c;
    int  stall;
    int  dc;
    int  k;
    int  exp_v;
    bit  degen;
    bit  exp_busy;
    bit  exp_done;
    degen  = (n == 0) || (m == 0) || (m > TM);
    nexp   = degen ? 0 : n * m;
    issued = 0;
    last_c = -10;
    stall  = 3;
    dc     = -1;
    for (int i = 0; i < 512; i++) begin
      iss[i]  = 0;
      beat[i] = 0;
    end
    tick();
    cfg_in_tiles  = CW'(n);
    cfg_out_sets  = CW'(m);
    cfg_feat_base = FW'(fb);
    cfg_wgt_base  = WW'(wb);
    start         = 1'b1;
    acc_ready     = 1'b1;
    sample();
    chk("start_busy", busy, 0);
    for (int c = 1; c < 400; c++) begin
      tick();
      start = 1'b0;
      if (mode == 1) begin
        acc_ready = 1'b1;
        if (issued == 1 && stall > 0) begin
          acc_ready = 1'b0;
          stall--;
        end
      end else if (mode == 2) begin
        acc_ready     = ($urandom_range(0, 3) != 0);
        start         = 1'($urandom_range(0, 1));
        cfg_in_tiles  = CW'($urandom);
        cfg_out_sets  = CW'($urandom);
        cfg_feat_base = FW'($urandom);
        cfg_wgt_base  = WW'($urandom);
      end else begin
        acc_ready = 1'b1;
      end
      sample();
      if (feat_rd_en) begin
        chk("issue_in_range", 32'(issued < nexp), 1);
        chk("wgt_en_pair", wgt_rd_en, 1);
        if (issued < nexp) begin
          chk("feat_addr", feat_rd_addr,
              (fb + issued % n) & 'hff);
          chk("wgt_addr", wgt_rd_addr, (wb + issued) & 'hfff);
        end
        iss[c]  = 1;
        beat[c] = issued;
        issued++;
        last_c  = c;
      end else begin
        chk("wgt_en_idle", wgt_rd_en, 0);
      end
      chk("array_enable", array_enable, iss[c-1]);
      exp_v = (c >= 2) ? iss[c-2] : 0;
      chk("acc_valid", acc_valid, exp_v);
      if (exp_v != 0) begin
        k = beat[c-2];
        chk("acc_first", acc_first, 32'((k % n) == 0));
        chk("acc_last", acc_last, 32'((k % n) == n - 1));
        chk("acc_set", acc_set, k / n);
      end
      exp_busy = !degen && (issued < nexp || c <= last_c + 2);
      chk("busy", busy, exp_busy);
      exp_done = degen ? (c == 1)
                       : (issued == nexp && c == last_c + 3);
      chk("done", done, exp_done);
      if (c == 1) chk("err_cleared", err_seq, 0);
      if (done) begin
        dc = c;
        break;
      end
    end
    chk("done_seen", 32'(dc > 0), 1);
    chk("issue_count", issued, nexp);
    chk("err_end", err_seq, exp_err);
    tick();
    start     = 1'b0;
    acc_ready = 1'b1;
    sample();
    chk("done_pulse_end", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rd_en", feat_rd_en, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    sample();
    chk_all_zero("reset");
    tick();
    rst = 1'b0;

    run_pass(3, 2, 'h10, 'h100, 0, 1'b0);
    run_pass(1, 4, 'h20, 'h200, 0, 1'b0);
    run_pass(4, 1, 'h30, 'h300, 1, 1'b0);
    run_pass(0, 2, 'h40, 'h400, 0, 1'b0);
    run_pass(3, 5, 'h50, 'h500, 0, 1'b0);
    run_pass(3, 0, 'h60, 'h600, 0, 1'b0);
    run_pass(3, 2, 'hfe, 'hffe, 0, 1'b0);
    repeat (4) begin
      run_pass(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
               int'($urandom_range(0, 255)),
               int'($urandom_range(0, 4095)), 2, 1'b0);
    end

    tick();
    cfg_in_tiles  = 8'd5;
    cfg_out_sets  = 8'd2;
    cfg_feat_base = 8'h70;
    cfg_wgt_base  = 12'h700;
    start         = 1'b1;
    acc_ready     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    chk_all_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      tick();
      sample();
      chk("midrst_no_done", done, 0);
      chk("midrst_no_busy", busy, 0);
    end
    run_pass(5, 2, 'h70, 'h700, 0, 1'b0);

    late = 1'b1;
    run_pass(3, 2, 'h80, 'h800, 0, 1'b1);
    repeat (3) tick();
    sample();
    chk("err_sticky", err_seq, 1);
    late = 1'b0;
    repeat (2) tick();
    sample();
    chk("err_still_sticky", err_seq, 1);
    run_pass(2, 3, 'h90, 'h900, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
